// File: rtl/adma_atx_cmpl.sv
// adma_atx_cmpl: completion tracker for scheduled AXI write transactions.
// Records accepted transactions in an in-order compacting table and matches
// B responses by ID (oldest first). Each match raises a registered per-channel
// done/err pulse; a B response that matches nothing raises bid_miss.
module adma_atx_cmpl #(
   parameter  int unsigned DMA_CHN_NUM   = 4,
   parameter  int unsigned MST_ID_W      = 5,
   parameter  int unsigned ATX_LEN_W     = 8,
   parameter  int unsigned ATX_NUM_OSTD  = 4,
   localparam int unsigned DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
   localparam int unsigned OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
   input  logic [MST_ID_W-1:0]      atx_awid,
   input  logic [ATX_LEN_W-1:0]     atx_awlen,
   input  logic                     atx_vld,
   output logic                     atx_rdy,
   input  logic [MST_ID_W-1:0]      bid,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   output logic [DMA_CHN_NUM-1:0]   atx_done,
   output logic [DMA_CHN_NUM-1:0]   atx_err,
   output logic                     bid_miss,
   output logic [OSTD_CNT_W-1:0]    ostd_cnt
);

   localparam int unsigned IDX_W = $clog2(ATX_NUM_OSTD);

   // Table state: slot 0 is always the oldest entry
   logic [ATX_NUM_OSTD-1:0]  slot_vld_q, slot_vld_d;
   logic [DMA_CHN_NUM_W-1:0] slot_chn_q [ATX_NUM_OSTD];
   logic [DMA_CHN_NUM_W-1:0] slot_chn_d [ATX_NUM_OSTD];
   logic [MST_ID_W-1:0]      slot_id_q  [ATX_NUM_OSTD];
   logic [MST_ID_W-1:0]      slot_id_d  [ATX_NUM_OSTD];
   logic [ATX_LEN_W-1:0]     slot_len_q [ATX_NUM_OSTD];
   logic [ATX_LEN_W-1:0]     slot_len_d [ATX_NUM_OSTD];
   logic [OSTD_CNT_W-1:0]    cnt_q, cnt_d, cnt_pop;

   logic [DMA_CHN_NUM-1:0]   done_q, done_d;
   logic [DMA_CHN_NUM-1:0]   err_q, err_d;
   logic                     miss_q, miss_d;

   logic                     hit;
   logic [IDX_W-1:0]         hit_idx;
   logic                     b_hs, push, pop;

   assign atx_rdy  = (cnt_q != OSTD_CNT_W'(ATX_NUM_OSTD));
   assign bready   = ~rst;
   assign b_hs     = bvalid & bready;
   assign push     = atx_vld & atx_rdy;
   assign pop      = b_hs & hit;
   assign cnt_pop  = cnt_q - OSTD_CNT_W'(pop);
   assign ostd_cnt = cnt_q;

   // A pulse still sitting in the output registers is masked while reset is high
   assign atx_done = done_q & {DMA_CHN_NUM{~rst}};
   assign atx_err  = err_q & {DMA_CHN_NUM{~rst}};
   assign bid_miss = miss_q & ~rst;

   // Oldest-match search over entries valid at cycle start (descending scan keeps lowest index)
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(ATX_NUM_OSTD) - 1; i >= 0; i--) begin
         if (slot_vld_q[i] && (slot_id_q[i] == bid)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Next table state: compact above the popped slot, then append at first free slot
   always_comb begin
      slot_vld_d = slot_vld_q;
      slot_chn_d = slot_chn_q;
      slot_id_d  = slot_id_q;
      slot_len_d = slot_len_q;
      if (pop) begin
         for (int i = 0; i < int'(ATX_NUM_OSTD) - 1; i++) begin
            if (i >= int'(hit_idx)) begin
               slot_vld_d[i] = slot_vld_q[i+1];
               slot_chn_d[i] = slot_chn_q[i+1];
               slot_id_d[i]  = slot_id_q[i+1];
               slot_len_d[i] = slot_len_q[i+1];
            end
         end
         slot_vld_d[ATX_NUM_OSTD-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < int'(ATX_NUM_OSTD); i++) begin
            if (OSTD_CNT_W'(i) == cnt_pop) begin
               slot_vld_d[i] = 1'b1;
               slot_chn_d[i] = atx_chn_id;
               slot_id_d[i]  = atx_awid;
               slot_len_d[i] = atx_awlen;
            end
         end
      end
      cnt_d = cnt_pop + OSTD_CNT_W'(push);
   end

   // Completion pulses for the matched entry's channel
   always_comb begin
      done_d = '0;
      err_d  = '0;
      if (pop) begin
         for (int c = 0; c < int'(DMA_CHN_NUM); c++) begin
            if (slot_chn_q[hit_idx] == DMA_CHN_NUM_W'(c)) begin
               done_d[c] = 1'b1;
               err_d[c]  = (bresp != 2'b00);
            end
         end
      end
      miss_d = b_hs & ~hit;
   end

   // Control state and pulse registers, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld_q <= '0;
         cnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         miss_q     <= 1'b0;
      end else begin
         slot_vld_q <= slot_vld_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         miss_q     <= miss_d;
      end
   end

   // Slot payload needs no reset; it is qualified by slot_vld_q
   always_ff @(posedge clk) begin
      slot_chn_q <= slot_chn_d;
      slot_id_q  <= slot_id_d;
      slot_len_q <= slot_len_d;
   end

endmodule

// File: tb/tb_adma_atx_cmpl.sv
// Self-checking bench for adma_atx_cmpl: a reference queue model predicts the
// response pulses, which are queued at drive time and compared after the edge.
module tb_adma_atx_cmpl;

   localparam int unsigned DMA_CHN_NUM  = 4;
   localparam int unsigned MST_ID_W     = 5;
   localparam int unsigned ATX_LEN_W    = 8;
   localparam int unsigned ATX_NUM_OSTD = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             atx_chn_id;
   logic [MST_ID_W-1:0]    atx_awid;
   logic [ATX_LEN_W-1:0]   atx_awlen;
   logic                   atx_vld;
   logic                   atx_rdy;
   logic [MST_ID_W-1:0]    bid;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [DMA_CHN_NUM-1:0] atx_done;
   logic [DMA_CHN_NUM-1:0] atx_err;
   logic                   bid_miss;
   logic [2:0]             ostd_cnt;

   typedef struct packed {
      logic [DMA_CHN_NUM-1:0] done;
      logic [DMA_CHN_NUM-1:0] err;
      logic                   miss;
   } exp_t;

   exp_t sb_q[$];
   int   mdl_chn[$];
   int   mdl_id[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   adma_atx_cmpl #(
      .DMA_CHN_NUM  (DMA_CHN_NUM),
      .MST_ID_W     (MST_ID_W),
      .ATX_LEN_W    (ATX_LEN_W),
      .ATX_NUM_OSTD (ATX_NUM_OSTD)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .atx_chn_id (atx_chn_id),
      .atx_awid   (atx_awid),
      .atx_awlen  (atx_awlen),
      .atx_vld    (atx_vld),
      .atx_rdy    (atx_rdy),
      .bid        (bid),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready),
      .atx_done   (atx_done),
      .atx_err    (atx_err),
      .bid_miss   (bid_miss),
      .ostd_cnt   (ostd_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus; model predicts the pulses that appear after the edge
   task automatic step(input logic pv, input int chn, input int id,
                       input logic bv, input int b_id, input logic [1:0] br);
      exp_t e;
      int   hit;
      bit   rdy_m;
      rdy_m = (mdl_id.size() != ATX_NUM_OSTD);
      check("atx_rdy", {31'd0, atx_rdy}, {31'd0, rdy_m});
      check("ostd_cnt", {29'd0, ostd_cnt}, mdl_id.size());
      check("bready", {31'd0, bready}, 32'd1);
      e   = '0;
      hit = -1;
      if (bv) begin
         for (int i = 0; i < mdl_id.size(); i++) begin
            if (hit < 0 && mdl_id[i] == b_id) hit = i;
         end
         if (hit >= 0) begin
            e.done[mdl_chn[hit]] = 1'b1;
            if (br != 2'b00) e.err[mdl_chn[hit]] = 1'b1;
            mdl_id.delete(hit);
            mdl_chn.delete(hit);
         end else begin
            e.miss = 1'b1;
         end
      end
      if (pv && rdy_m) begin
         mdl_id.push_back(id);
         mdl_chn.push_back(chn);
      end
      atx_vld    = pv;
      atx_chn_id = 2'(chn);
      atx_awid   = MST_ID_W'(id);
      atx_awlen  = ATX_LEN_W'(id + 3);
      bvalid     = bv;
      bid        = MST_ID_W'(b_id);
      bresp      = br;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      atx_vld = 1'b0;
      bvalid  = 1'b0;
      e = sb_q.pop_front();
      check("atx_done", {28'd0, atx_done}, {28'd0, e.done});
      check("atx_err", {28'd0, atx_err}, {28'd0, e.err});
      check("bid_miss", {31'd0, bid_miss}, {31'd0, e.miss});
   endtask

   task automatic push_atx(input int chn, input int id);
      step(1'b1, chn, id, 1'b0, 0, 2'b00);
   endtask

   task automatic resp(input int b_id, input logic [1:0] br);
      step(1'b0, 0, 0, 1'b1, b_id, br);
   endtask

   task automatic idle();
      step(1'b0, 0, 0, 1'b0, 0, 2'b00);
   endtask

   initial begin
      rst        = 1'b1;
      atx_vld    = 1'b0;
      atx_chn_id = '0;
      atx_awid   = '0;
      atx_awlen  = '0;
      bvalid     = 1'b0;
      bid        = '0;
      bresp      = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_cnt", {29'd0, ostd_cnt}, 32'd0);
      check("rst_rdy", {31'd0, atx_rdy}, 32'd1);
      check("rst_done", {28'd0, atx_done}, 32'd0);
      check("rst_miss", {31'd0, bid_miss}, 32'd0);

      // Single transaction
      push_atx(2, 5);
      resp(5, 2'b00);
      idle();

      // Fill to full, hold a 5th offer, pop a middle entry
      push_atx(0, 1);
      push_atx(1, 2);
      push_atx(2, 3);
      push_atx(3, 4);
      step(1'b1, 1, 6, 1'b0, 0, 2'b00);
      step(1'b1, 1, 6, 1'b1, 3, 2'b00);
      step(1'b1, 1, 6, 1'b0, 0, 2'b00);
      resp(4, 2'b00);
      resp(1, 2'b00);
      resp(2, 2'b00);
      resp(6, 2'b00);
      idle();

      // Same-ID ordering
      push_atx(0, 7);
      push_atx(1, 7);
      resp(7, 2'b00);
      resp(7, 2'b00);
      idle();

      // Same-cycle push and pop at three entries; new entry lands behind older id 9
      push_atx(0, 12);
      push_atx(2, 9);
      push_atx(3, 13);
      step(1'b1, 1, 9, 1'b1, 12, 2'b00);
      idle();
      resp(9, 2'b00);
      resp(9, 2'b00);
      resp(13, 2'b00);

      // Same-cycle push is invisible to that cycle's B
      step(1'b1, 2, 20, 1'b1, 20, 2'b00);
      resp(20, 2'b11);

      // Error response and miss on empty table
      push_atx(3, 8);
      resp(8, 2'b10);
      resp(31, 2'b00);
      idle();

      // Reset mid-operation with a completion pulse pending
      push_atx(0, 1);
      push_atx(1, 2);
      push_atx(2, 3);
      bvalid = 1'b1;
      bid    = MST_ID_W'(1);
      bresp  = 2'b00;
      @(posedge clk);
      #1;
      bvalid = 1'b0;
      rst    = 1'b1;
      #1;
      check("rst_mid_done", {28'd0, atx_done}, 32'd0);
      check("rst_mid_err", {28'd0, atx_err}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mdl_id.delete();
      mdl_chn.delete();
      #1;
      check("rst_mid_cnt", {29'd0, ostd_cnt}, 32'd0);
      check("rst_mid_rdy", {31'd0, atx_rdy}, 32'd1);
      idle();
      resp(2, 2'b00);
      push_atx(1, 4);
      resp(4, 2'b01);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adma_atx_cmpl.md
Name: adma_atx_cmpl

Overview:
- Completion tracker at the consumer end of the DMA AXI-transaction (atx) interface.
- Accepts each scheduled transaction from the atx scheduler and records it in an in-order outstanding table.
- Matches AXI write responses (B channel) to the recorded transactions and returns per-channel atx_done / atx_err pulses to the per-channel requesters.
- Sits between the atx scheduler and the AXI master write-response path.

Parameters:
- DMA_CHN_NUM, 4, number of DMA channels
- MST_ID_W, 5, AXI ID width
- ATX_LEN_W, 8, AXI burst length width
- ATX_NUM_OSTD, 4, outstanding table depth (>=2)
- DMA_CHN_NUM_W, (DMA_CHN_NUM>1)?$clog2(DMA_CHN_NUM):1, channel index width (derived, do not set)
- OSTD_CNT_W, $clog2(ATX_NUM_OSTD+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- atx_chn_id  in  DMA_CHN_NUM_W  channel owning the offered transaction
- atx_awid  in  MST_ID_W  AXI write ID of the offered transaction
- atx_awlen  in  ATX_LEN_W  burst length, stored for debug/readback only
- atx_vld  in  1  transaction offered
- atx_rdy  out  1  table can accept
- bid  in  MST_ID_W  write-response ID
- bresp  in  2  write-response code
- bvalid  in  1  response valid
- bready  out  1  response accepted
- atx_done  out  DMA_CHN_NUM  one-cycle completion pulse per channel
- atx_err  out  DMA_CHN_NUM  one-cycle pulse: completed transaction had bresp != 2'b00
- bid_miss  out  1  one-cycle pulse: accepted B matched no entry
- ostd_cnt  out  OSTD_CNT_W  valid entries in the table

Behaviour:
- Reset (rst=1 at clk edge): all entries invalid; ostd_cnt=0; atx_done, atx_err, bid_miss = 0; atx_rdy=1 and bready=1 from the first cycle after reset.
- Table organisation: compacting queue with slots 0..ATX_NUM_OSTD-1 in issue order. Slot 0 is the oldest. Each slot holds {vld, chn_id, awid, awlen}.
- Accept rule:
  - atx_rdy = (ostd_cnt != ATX_NUM_OSTD), driven from registered state. There is no full-bypass, even when a B pops in the same cycle.
  - Push occurs on atx_vld & atx_rdy. The new entry is written to the first free slot after any same-cycle compaction.
- Response rule:
  - bready = 1 whenever rst=0. Every B is accepted in one cycle.
  - On bvalid: search the slots valid at cycle start for the lowest index with awid == bid. This is the oldest match, which preserves AXI same-ID ordering.
  - On a match: remove that slot, shift all higher slots down by one, and decrement ostd_cnt.
  - No match: table unchanged; bid_miss pulses the next cycle.
- Output latency:
  - atx_done[chn_id of matched entry] is registered and pulses exactly 1 cycle after the B handshake.
  - atx_err[same chn] pulses in the same cycle if bresp != 0.
  - All other bits of atx_done and atx_err are 0.
- Simultaneous push and pop:
  - Both happen in the same cycle; ostd_cnt is unchanged.
  - A same-cycle push is invisible to that cycle's B search. A B can never match a transaction accepted in the same cycle.
- Full: when ostd_cnt == ATX_NUM_OSTD, atx_rdy=0. atx_rdy rises the cycle after any matching pop.
- Empty: a B arriving while ostd_cnt=0 gives bid_miss only.
- Different IDs may complete out of order; a middle slot is removed and the queue compacts.
- Reset mid-operation: all entries are discarded with no done pulses. A pulse that was pending is suppressed if rst is high in that cycle.
- ostd_cnt never exceeds ATX_NUM_OSTD and never underflows.

Test Plan:
- Single transaction: push chn=2, id=5; then B bid=5, bresp=0 -> atx_done=4'b0100 one cycle after the B handshake, atx_err=0, ostd_cnt 1->0.
- Fill to full: push 4 entries (ids 1,2,3,4) -> atx_rdy=0 with ostd_cnt=4. A 5th atx_vld is held. B bid=3 -> next cycle atx_rdy=1 and slots hold ids 1,2,4.
- Same-ID ordering: push (chn0,id7) then (chn1,id7); B bid=7 twice -> done pulses chn0 first, then chn1.
- Same-cycle push + B at full-minus-one: ostd_cnt=3, push id9 and B matching slot0 in the same cycle -> ostd_cnt stays 3 and id9 lands in slot 2.
- Error and miss: B bresp=2'b10 matching chn3 -> atx_done[3]=1 and atx_err[3]=1. B bid=31 with no entry -> bid_miss=1, atx_done=0.
- Reset mid-operation: 3 entries outstanding, assert rst for 1 cycle -> ostd_cnt=0, no done pulses, atx_rdy=1 the next cycle.
